// File: rtl/grf_write_arbiter_pkg.sv
// Shared types for the GRF write-port arbiter: widths, the buffered write-back
// record and the register one-hot decode used to build the pending mask.
package grf_write_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_W;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_md_result_fifo.sv
// Circular buffer of multiply/divide results awaiting the GRF write port.
// Entries can be invalidated in place when a younger write targets the same register.
module md_result_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enq_i,
  input  wb_entry_t        enqEntry_i,
  input  logic             pop_i,
  input  logic             squashEn_i,
  input  logic [REG_W-1:0] squashReg_i,
  output logic             full_o,
  output logic             empty_o,
  output wb_entry_t        head_o,
  output logic [NREGS-1:0] pendingMask_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             doEnq, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign doEnq   = enq_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // A popped slot drops its valid bit so the pending mask forgets it next cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doEnq && (tail_q == PTR_W'(i))) begin
          mem_q[i] <= enqEntry_i;
        end else if (doPop && (head_q == PTR_W'(i))) begin
          mem_q[i].valid <= 1'b0;
        end else if (squashEn_i && (mem_q[i].rd == squashReg_i)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (doEnq) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (doPop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({doEnq, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    pendingMask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid) begin
        pendingMask_o = pendingMask_o | reg_onehot(mem_q[i].rd);
      end
    end
    pendingMask_o[0] = 1'b0;
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Single owner of the GRF write port: pipeline results take priority, buffered
// MD results fill idle slots, and a starvation counter forces an MD slot when needed.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pipeValid_i,
  input  logic [REG_W-1:0]  pipeReg_i,
  input  logic [DATA_W-1:0] pipeData_i,
  input  logic [DATA_W-1:0] pipePC_i,
  output logic              pipeStall_o,
  input  logic              mdValid_i,
  output logic              mdReady_o,
  input  logic [REG_W-1:0]  mdReg_i,
  input  logic [DATA_W-1:0] mdData_i,
  input  logic [DATA_W-1:0] mdPC_i,
  output logic              regWrite_o,
  output logic [REG_W-1:0]  writeReg_o,
  output logic [DATA_W-1:0] writeData_o,
  output logic [DATA_W-1:0] wpc_o,
  output logic [NREGS-1:0]  pendingMask_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                stall_q, stall_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                regWrite_q, regWrite_d;
  logic [REG_W-1:0]    writeReg_q, writeReg_d;
  logic [DATA_W-1:0]   writeData_q, writeData_d;
  logic [DATA_W-1:0]   wpc_q, wpc_d;

  logic      pipeWrite, pop, mdEnq;
  logic      fifoFull, fifoEmpty;
  wb_entry_t enqEntry, headEntry;

  md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enq_i         (mdEnq),
    .enqEntry_i    (enqEntry),
    .pop_i         (pop),
    .squashEn_i    (pipeWrite),
    .squashReg_i   (pipeReg_i),
    .full_o        (fifoFull),
    .empty_o       (fifoEmpty),
    .head_o        (headEntry),
    .pendingMask_o (pendingMask_o)
  );

  // A pipeline write to r0 is absorbed without using the port, so the FIFO may still pop.
  always_comb begin
    pipeWrite = pipeValid_i && !stall_q && (pipeReg_i != '0);
    pop       = !fifoEmpty && !pipeWrite;
    mdEnq     = mdValid_i && !fifoFull && (mdReg_i != '0);

    enqEntry.valid = !(pipeWrite && (mdReg_i == pipeReg_i));
    enqEntry.rd    = mdReg_i;
    enqEntry.data  = mdData_i;
    enqEntry.pc    = mdPC_i;

    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    wpc_d       = wpc_q;
    if (pipeWrite) begin
      regWrite_d  = 1'b1;
      writeReg_d  = pipeReg_i;
      writeData_d = pipeData_i;
      wpc_d       = pipePC_i;
    end else if (pop && headEntry.valid) begin
      regWrite_d  = 1'b1;
      writeReg_d  = headEntry.rd;
      writeData_d = headEntry.data;
      wpc_d       = headEntry.pc;
    end

    starve_d = (fifoEmpty || pop) ? '0 : starve_q + STARVE_W'(1);
    stall_d  = (starve_d == STARVE_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q     <= 1'b0;
      starve_q    <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      wpc_q       <= '0;
    end else begin
      stall_q     <= stall_d;
      starve_q    <= starve_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      wpc_q       <= wpc_d;
    end
  end

  assign pipeStall_o = stall_q;
  assign mdReady_o   = !fifoFull;
  assign regWrite_o  = regWrite_q;
  assign writeReg_o  = writeReg_q;
  assign writeData_o = writeData_q;
  assign wpc_o       = wpc_q;

endmodule
